// File: rtl/data_mem_responder.sv
// Load/store responder for the single-issue core: word-organised little-endian RAM with
// byte/half/word lanes, sign/zero extension, fixed LATENCY and a ready/valid handshake.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        access_err
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        q_rd, q_wr;
    logic [2:0]  q_f3;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] mem [DEPTH];

    logic                  accept, commit;
    logic                  c_rd, c_wr;
    logic [2:0]            c_f3;
    logic [31:0]           c_addr, c_wdata;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [1:0]            c_lane;
    logic [31:0]           c_word, c_shift, c_load, c_wsh, c_merged, c_rdata;
    logic [3:0]            c_be;
    logic                  c_illegal, c_misalign, c_err;
    logic                  unused_hi;

    assign accept = req_ready && (mem_read_en || mem_write_en);

    // With LATENCY=1 the commit happens on the accept edge, so the request comes from the ports.
    always_comb begin
        if (state == IDLE) begin
            c_rd    = mem_read_en;
            c_wr    = mem_write_en;
            c_f3    = funct3;
            c_addr  = addr;
            c_wdata = wdata;
        end else begin
            c_rd    = q_rd;
            c_wr    = q_wr;
            c_f3    = q_f3;
            c_addr  = q_addr;
            c_wdata = q_wdata;
        end
    end

    assign commit = (state == IDLE && accept && LATENCY == 1) ||
                    (state == WAIT && cnt == 4'd1);

    assign c_idx     = c_addr[ADDR_WIDTH+1:2];
    assign c_lane    = c_addr[1:0];
    assign c_word    = mem[c_idx];
    assign unused_hi = ^c_addr[31:ADDR_WIDTH+2];

    always_comb begin
        c_illegal = 1'b0;
        if (c_wr) begin
            c_illegal = c_f3[2] || (c_f3[1:0] == 2'b11);
        end else begin
            case (c_f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: c_illegal = 1'b0;
                default:                                c_illegal = 1'b1;
            endcase
        end
        c_misalign = (c_f3[1:0] == 2'b01 && c_lane[0]) ||
                     (c_f3[1:0] == 2'b10 && c_lane != 2'b00);
        c_err      = (c_rd && c_wr) || c_illegal || c_misalign;
    end

    always_comb begin
        c_shift = c_word >> {c_lane, 3'b000};
        case (c_f3)
            3'b000:  c_load = {{24{c_shift[7]}}, c_shift[7:0]};
            3'b001:  c_load = {{16{c_shift[15]}}, c_shift[15:0]};
            3'b010:  c_load = c_word;
            3'b100:  c_load = {24'b0, c_shift[7:0]};
            3'b101:  c_load = {16'b0, c_shift[15:0]};
            default: c_load = 32'b0;
        endcase
        c_rdata = (c_err || c_wr) ? 32'b0 : c_load;
    end

    // Store data is shifted into its lane; the byte enables pick which lanes replace the old word.
    always_comb begin
        c_wsh = c_wdata << {c_lane, 3'b000};
        case (c_f3[1:0])
            2'b00:   c_be = 4'b0001 << c_lane;
            2'b01:   c_be = 4'b0011 << c_lane;
            default: c_be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            c_merged[8*i +: 8] = c_be[i] ? c_wsh[8*i +: 8] : c_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr && !c_err) begin
            mem[c_idx] <= c_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'b0;
            access_err <= 1'b0;
            q_rd       <= 1'b0;
            q_wr       <= 1'b0;
            q_f3       <= 3'b0;
            q_addr     <= 32'b0;
            q_wdata    <= 32'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_rd      <= mem_read_en;
                        q_wr      <= mem_write_en;
                        q_f3      <= funct3;
                        q_addr    <= addr;
                        q_wdata   <= wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            rdata      <= c_rdata;
                            access_err <= c_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        rdata      <= c_rdata;
                        access_err <= c_err;
                    end
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    cnt       <= 4'd0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
